trisc_control_sequencer: RTL and testbench
==========================================

Name: trisc_control_sequencer

Overview:
- Multi-cycle control sequencer for the TRISC accumulator CPU; consumes the one-hot instruction decode (16-bit, bit 0 = opcode 0000) produced from the IR opcode.
- Runs fetch/decode/execute and drives the datapath strobes (MAR source, memory read/write, IR/PC/ACC loads, ALU op).
- Handles a req/ack memory handshake with timeout, counts retired instructions, and flags illegal decodes.

Parameters:
- CNT_W, 16, width of retired-instruction counter (saturating)
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack before error halt (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; leaves IDLE/HALT and begins fetch
- dec_y  in  [0:15]  one-hot decode. Bit positions: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 XOR, 5 INC, 6 CLR, 7 JMP, 8 JPN, 9 JPZ, 10 HLT; 11-15 unused
- flag_z  in  1  accumulator zero flag
- flag_n  in  1  accumulator negative flag
- mem_ack  in  1  memory done; read data valid while high
- pc_to_mar  out  1  MAR <= PC
- ir_to_mar  out  1  MAR <= IR address field
- mem_rd  out  1  read request
- mem_wr  out  1  write request (ACC drives data)
- ir_load  out  1  IR <= memory data
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= IR address field
- acc_load  out  1  ACC <= ALU result
- acc_clr  out  1  ACC <= 0
- alu_op  out  3  000 PASS, 001 ADD, 010 SUB, 011 XOR, 100 INC
- busy  out  1  state not IDLE/HALT
- halted  out  1  in HALT
- illegal  out  1  sticky: latched decode not exactly one-hot among bits 0-10
- mem_err  out  1  sticky: handshake timeout
- instr_count  out  CNT_W  retired instructions, saturates at all-ones

Behaviour:
- Reset (async, immediate, including mid-transfer): state IDLE; all outputs 0; alu_op 000; count, wait timer and op_q cleared.
- States: IDLE, F_ADDR, F_READ, DECODE, E_ADDR, E_MEM, E_WB, HALT.
- Strobes are Moore decodes of state and op_q, except ir_load/pc_inc (F_READ & mem_ack).
- IDLE: start -> F_ADDR. HALT: start -> F_ADDR and clears halted/illegal/mem_err; otherwise stay.
- F_ADDR: pc_to_mar=1 -> F_READ.
- F_READ: mem_rd=1 held until ack. On the ack cycle ir_load=1 and pc_inc=1 -> DECODE.
- DECODE: op_q <= dec_y. Routing:
  - LDA, STA, ADD, SUB, XOR -> E_ADDR
  - INC, CLR, JMP, JPZ, JPN -> E_WB
  - HLT -> HALT (retired)
  - all-zero or multi-hot among bits 0-10 -> illegal=1, HALT (not retired)
- E_ADDR: ir_to_mar=1 -> E_MEM.
- E_MEM: STA holds mem_wr=1; others hold mem_rd=1. On ack: STA -> F_ADDR (retired); others -> E_WB.
- E_WB, one cycle, then -> F_ADDR (retired):
  - LDA: acc_load, PASS
  - ADD/SUB/XOR/INC: acc_load with matching op
  - CLR: acc_clr
  - JMP: pc_load
  - JPZ: pc_load iff flag_z
  - JPN: pc_load iff flag_n (flags sampled this cycle)
- Latency with ack in the request cycle:
  - LDA/ADD/SUB/XOR: 6 cycles
  - STA: 5 cycles
  - INC/CLR/JMP/JPZ/JPN: 4 cycles
  - HLT: 3 cycles to HALT
- Wait timer: counts each F_READ/E_MEM cycle without ack; clears on ack or state change. When it reaches MEM_TIMEOUT: mem_err=1, drop request, -> HALT.
- mem_ack outside F_READ/E_MEM is ignored.
- start while busy is ignored.
- instr_count increments on retire, saturating; never cleared except by reset.

Decomposition:
- Package trisc_pkg: dec_y bit-index constants, alu_op encodings, state enum.
- Wait timer stays inline; no sub-module.

Test Plan:
- Reset mid-E_MEM with mem_wr=1 -> all strobes 0 same cycle, state IDLE, instr_count=0.
- start, then LDA, ADD, STA, HLT with ack in the request cycle -> 6/6/5/3-cycle spacing; alu_op 000 then 001; instr_count=4; halted=1.
- JPZ with flag_z=0, then JPZ with flag_z=1 -> pc_load 0 then 1, each in E_WB; JPN with flag_n=1 -> pc_load=1.
- mem_ack delayed 3 cycles in F_READ -> mem_rd held 4 cycles, single ir_load/pc_inc pulse on the ack cycle.
- No ack for 15 cycles -> mem_err=1, HALT; start -> mem_err cleared, fetch resumes.
- dec_y=0 or bits 0 and 2 both set at DECODE -> illegal=1, HALT, count unchanged; instr_count at 16'hFFFF stays 16'hFFFF after another retire.

Source files
------------

// File: rtl/trisc_pkg.sv
// Shared constants for the TRISC control sequencer: decode bit positions,
// ALU op encodings and the sequencer state enum.
package trisc_pkg;

    // Bit positions in the one-hot opcode decode (bit 0 = opcode 0000)
    localparam int OP_LDA  = 0;
    localparam int OP_STA  = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_INC  = 5;
    localparam int OP_CLR  = 6;
    localparam int OP_JMP  = 7;
    localparam int OP_JPN  = 8;
    localparam int OP_JPZ  = 9;
    localparam int OP_HLT  = 10;
    localparam int OP_LAST = OP_HLT;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_INC  = 3'b100
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F_ADDR,
        S_F_READ,
        S_DECODE,
        S_E_ADDR,
        S_E_MEM,
        S_E_WB,
        S_HALT
    } state_e;

    // A decode is legal only when exactly one defined opcode bit is set
    function automatic logic dec_legal(input logic [0:OP_LAST] d);
        return $countones(d) == 1;
    endfunction

endpackage

// File: rtl/trisc_control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the TRISC accumulator CPU.
// Drives datapath strobes, runs a req/ack memory handshake with timeout,
// counts retired instructions and flags illegal decodes.
module trisc_control_sequencer
    import trisc_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:15]      dec_y,
    input  logic             flag_z,
    input  logic             flag_n,
    input  logic             mem_ack,
    output logic             pc_to_mar,
    output logic             ir_to_mar,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             acc_load,
    output logic             acc_clr,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [0:OP_LAST]  op_q;
    logic [TW-1:0]     wait_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              illegal_q, mem_err_q;
    logic              retire, set_illegal, timeout, wait_st, wait_hit;
    logic              unused_dec;

    // Opcodes 11-15 carry no meaning; only bits 0-10 take part in decode
    assign unused_dec = ^dec_y[OP_LAST+1:15];

    assign wait_st  = (state_q == S_F_READ) || (state_q == S_E_MEM);
    // This no-ack cycle is the one that brings the wait count to the limit
    assign wait_hit = wait_st && !mem_ack && (wait_q == TW'(MEM_TIMEOUT - 1));

    // Next-state logic and Moore strobe decode (ir_load/pc_inc also use mem_ack)
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        timeout     = 1'b0;
        pc_to_mar   = 1'b0;
        ir_to_mar   = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        acc_load    = 1'b0;
        acc_clr     = 1'b0;
        alu_op      = ALU_PASS;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_F_ADDR;
            S_F_ADDR: begin
                pc_to_mar = 1'b1;
                state_d   = S_F_READ;
            end
            S_F_READ: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (!dec_legal(dec_y[0:OP_LAST])) begin
                    set_illegal = 1'b1;
                    state_d     = S_HALT;
                end else if (dec_y[OP_HLT]) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else if (dec_y[OP_LDA] || dec_y[OP_STA] || dec_y[OP_ADD] ||
                             dec_y[OP_SUB] || dec_y[OP_XOR]) begin
                    state_d = S_E_ADDR;
                end else begin
                    state_d = S_E_WB;
                end
            end
            S_E_ADDR: begin
                ir_to_mar = 1'b1;
                state_d   = S_E_MEM;
            end
            S_E_MEM: begin
                mem_wr = op_q[OP_STA];
                mem_rd = !op_q[OP_STA];
                if (mem_ack) begin
                    if (op_q[OP_STA]) begin
                        retire  = 1'b1;
                        state_d = S_F_ADDR;
                    end else begin
                        state_d = S_E_WB;
                    end
                end else if (wait_hit) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_E_WB: begin
                retire  = 1'b1;
                state_d = S_F_ADDR;
                if (op_q[OP_LDA]) begin
                    acc_load = 1'b1;
                    alu_op   = ALU_PASS;
                end else if (op_q[OP_ADD]) begin
                    acc_load = 1'b1;
                    alu_op   = ALU_ADD;
                end else if (op_q[OP_SUB]) begin
                    acc_load = 1'b1;
                    alu_op   = ALU_SUB;
                end else if (op_q[OP_XOR]) begin
                    acc_load = 1'b1;
                    alu_op   = ALU_XOR;
                end else if (op_q[OP_INC]) begin
                    acc_load = 1'b1;
                    alu_op   = ALU_INC;
                end else if (op_q[OP_CLR]) begin
                    acc_clr = 1'b1;
                end else if (op_q[OP_JMP]) begin
                    pc_load = 1'b1;
                end else if (op_q[OP_JPZ]) begin
                    pc_load = flag_z;
                end else if (op_q[OP_JPN]) begin
                    pc_load = flag_n;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched opcode, sticky flags and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= dec_y[0:OP_LAST];
            if (retire && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
            if ((state_q == S_HALT) && start) begin
                illegal_q <= 1'b0;
                mem_err_q <= 1'b0;
            end
            if (set_illegal) illegal_q <= 1'b1;
            if (timeout)     mem_err_q <= 1'b1;
        end
    end

    // Handshake wait timer: counts consecutive no-ack cycles within one wait state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         wait_q <= '0;
        else if (!wait_st || mem_ack || state_d != state_q) wait_q <= '0;
        else                                                wait_q <= wait_q + 1'b1;
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign mem_err     = mem_err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_trisc_control_sequencer.sv
// Scoreboard bench for trisc_control_sequencer: a driver acts as memory and
// issues randomized programs, pushing per-instruction expectations computed
// from the instruction-level timing rules; a monitor measures each
// instruction window (fetch to next fetch or halt) and compares.
module tb_trisc_control_sequencer;

    localparam int L_LDA = 0, L_STA = 1, L_ADD = 2, L_SUB = 3, L_XOR = 4;
    localparam int L_INC = 5, L_CLR = 6, L_JMP = 7, L_JPN = 8, L_JPZ = 9, L_HLT = 10;
    localparam int TMO = 15;

    typedef struct {
        logic [0:15] dec;
        bit          z, n;
        int          df, de;
        bit          last;
    } instr_t;

    typedef struct {
        int cycles, mrd, mwr, irl, acl, aclr, pcl, alu, retire, endk, cnt;
    } exp_t;

    logic        clk = 1'b0, rst_n, start, flag_z, flag_n, mem_ack;
    logic [0:15] dec_y;
    logic        pc_to_mar, ir_to_mar, mem_rd, mem_wr, ir_load, pc_inc, pc_load;
    logic        acc_load, acc_clr, busy, halted, illegal, mem_err;
    logic [2:0]  alu_op;
    logic [15:0] instr_count;
    logic        s_pc_to_mar, s_ir_to_mar, s_mem_rd, s_mem_wr, s_ir_load, s_pc_inc, s_pc_load;
    logic        s_acc_load, s_acc_clr, s_busy, s_halted, s_illegal, s_mem_err;
    logic [2:0]  s_alu_op;
    logic [2:0]  s_instr_count;

    int     total = 0, passed = 0, exp_cnt = 0;
    bit     mon_en = 0;
    instr_t prog[$];
    exp_t   sb[$];

    trisc_control_sequencer #(.CNT_W(16), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dec_y(dec_y), .flag_z(flag_z),
        .flag_n(flag_n), .mem_ack(mem_ack), .pc_to_mar(pc_to_mar), .ir_to_mar(ir_to_mar),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .acc_load(acc_load), .acc_clr(acc_clr), .alu_op(alu_op),
        .busy(busy), .halted(halted), .illegal(illegal), .mem_err(mem_err),
        .instr_count(instr_count));

    // Narrow-counter twin on the same inputs, used to observe saturation
    trisc_control_sequencer #(.CNT_W(3), .MEM_TIMEOUT(TMO)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .dec_y(dec_y), .flag_z(flag_z),
        .flag_n(flag_n), .mem_ack(mem_ack), .pc_to_mar(s_pc_to_mar), .ir_to_mar(s_ir_to_mar),
        .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .ir_load(s_ir_load), .pc_inc(s_pc_inc),
        .pc_load(s_pc_load), .acc_load(s_acc_load), .acc_clr(s_acc_clr), .alu_op(s_alu_op),
        .busy(s_busy), .halted(s_halted), .illegal(s_illegal), .mem_err(s_mem_err),
        .instr_count(s_instr_count));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s", name);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:15] oh(input int k);
        logic [0:15] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] strobes();
        return {pc_to_mar, ir_to_mar, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load,
                acc_clr, alu_op, busy, halted, illegal, mem_err, instr_count};
    endfunction

    function automatic instr_t mk(input logic [0:15] d, input bit z, input bit n,
                                  input int df, input int de, input bit last);
        instr_t i;
        i.dec = d; i.z = z; i.n = n; i.df = df; i.de = de; i.last = last;
        return i;
    endfunction

    // Instruction-level reference: cycle budget per phase and expected strobes
    function automatic exp_t model(input instr_t i);
        exp_t e;
        int   ones, op;
        e = '{default: 0};
        ones = 0; op = -1;
        for (int b = 0; b <= L_HLT; b++) if (i.dec[b]) begin ones++; op = b; end
        e.cycles = 1;                                   // address phase
        if (i.df >= TMO) begin
            e.cycles += TMO; e.mrd = TMO; e.endk = 3;
            return e;
        end
        e.cycles += i.df + 1; e.mrd = i.df + 1; e.irl = 1;
        e.cycles += 1;                                  // decode
        if (ones != 1) begin e.endk = 2; return e; end
        if (op == L_HLT) begin e.retire = 1; e.endk = 1; return e; end
        if (op <= L_XOR) begin
            e.cycles += 1;                              // operand address
            if (i.de >= TMO) begin
                e.cycles += TMO;
                if (op == L_STA) e.mwr = TMO; else e.mrd += TMO;
                e.endk = 3;
                return e;
            end
            e.cycles += i.de + 1;
            if (op == L_STA) begin e.mwr = i.de + 1; e.retire = 1; return e; end
            e.mrd += i.de + 1;
        end
        e.cycles += 1;                                  // write-back
        e.retire = 1;
        case (op)
            L_LDA: begin e.acl = 1; e.alu = 0; end
            L_ADD: begin e.acl = 1; e.alu = 1; end
            L_SUB: begin e.acl = 1; e.alu = 2; end
            L_XOR: begin e.acl = 1; e.alu = 3; end
            L_INC: begin e.acl = 1; e.alu = 4; end
            L_CLR: e.aclr = 1;
            L_JMP: e.pcl  = 1;
            L_JPZ: e.pcl  = i.z ? 1 : 0;
            L_JPN: e.pcl  = i.n ? 1 : 0;
            default: ;
        endcase
        return e;
    endfunction

    function automatic int rnd_delay();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TMO - 1)) : 0;
    endfunction

    task automatic build_programs();
        int a, b, n, t;
        prog.push_back(mk(oh(L_LDA), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_ADD), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_STA), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_HLT), 0, 0, 0, 0, 1));
        prog.push_back(mk(oh(L_JPZ), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_JPZ), 1, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_JPN), 0, 1, 0, 0, 0));
        prog.push_back(mk(oh(L_LDA), 0, 0, 3, 0, 0));
        prog.push_back(mk(oh(L_CLR), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_INC), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_JMP), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_SUB), 0, 0, 0, 2, 0));
        prog.push_back(mk(oh(L_XOR), 0, 0, 0, TMO - 1, 0));
        prog.push_back(mk(16'h0000, 0, 0, 0, 0, 1));
        prog.push_back(mk(oh(L_LDA), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_LDA) | oh(L_ADD), 0, 0, 0, 0, 1));
        prog.push_back(mk(oh(L_ADD), 0, 0, 0, 0, 0));
        prog.push_back(mk(oh(L_INC), 0, 0, TMO + 5, 0, 1));
        prog.push_back(mk(oh(L_STA), 0, 0, 0, TMO + 5, 1));
        prog.push_back(mk(oh(L_HLT), 0, 0, 1, 0, 1));
        for (int p = 0; p < 30; p++) begin
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++)
                prog.push_back(mk(oh($urandom_range(0, 9)), 1'($urandom), 1'($urandom),
                                  rnd_delay(), rnd_delay(), 0));
            t = $urandom_range(0, 3);
            case (t)
                0: prog.push_back(mk(oh(L_HLT), 0, 0, rnd_delay(), 0, 1));
                1: begin
                    a = $urandom_range(0, 10);
                    b = (a + $urandom_range(1, 10)) % 11;
                    prog.push_back(mk(($urandom_range(0, 2) == 0) ? 16'h0000 : (oh(a) | oh(b)),
                                      0, 0, 0, 0, 1));
                end
                2: prog.push_back(mk(oh($urandom_range(0, 9)), 0, 0,
                                     TMO + $urandom_range(0, 3), 0, 1));
                default: prog.push_back(mk(oh($urandom_range(0, 4)), 0, 0, 0,
                                           TMO + $urandom_range(0, 3), 1));
            endcase
        end
    endtask

    // Memory/driver: start one program and answer requests until it halts
    task automatic run_program();
        instr_t cur;
        exp_t   e;
        int     w, guard;
        bit     phase, popped_last, done;
        cur = mk('0, 0, 0, 0, 0, 0);
        w = 0; guard = 0; phase = 0; popped_last = 0; done = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        while (!done) begin
            if (pc_to_mar) begin
                if (popped_last || prog.size() == 0) begin
                    fail_now("unexpected_fetch");
                    done = 1;
                end else begin
                    cur = prog.pop_front();
                    popped_last = cur.last;
                    e = model(cur);
                    exp_cnt = (exp_cnt + e.retire > 65535) ? 65535 : exp_cnt + e.retire;
                    e.cnt = exp_cnt;
                    sb.push_back(e);
                    dec_y = cur.dec; flag_z = cur.z; flag_n = cur.n;
                    phase = 0; w = 0;
                end
            end
            if (ir_to_mar) begin phase = 1; w = 0; end
            if (mem_rd || mem_wr) begin
                mem_ack = (w == (phase ? cur.de : cur.df));
                w++;
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
            end
            start = busy && ($urandom_range(0, 7) == 0);
            if (!done) cycle();
            guard++;
            if (halted) done = 1;
            if (!done && guard > 200) begin
                fail_now("program_timeout");
                done = 1;
            end
        end
        start = 1'b0;
        mem_ack = 1'b0;
    endtask

    // Monitor: measure each instruction window and compare against the scoreboard
    int cyc, mrd, mwr, irl, pinc, acl, aclr, pcl, alu_or;
    bit inwin = 0;

    task automatic close_win();
        exp_t e;
        int   obs_end;
        if (sb.size() == 0) begin
            fail_now("scoreboard_underflow");
            return;
        end
        e = sb.pop_front();
        obs_end = !halted ? 0 : mem_err ? 3 : illegal ? 2 : 1;
        chk("cycles", cyc, e.cycles);
        chk("mem_rd_cycles", mrd, e.mrd);
        chk("mem_wr_cycles", mwr, e.mwr);
        chk("ir_load_pulses", irl, e.irl);
        chk("pc_inc_pulses", pinc, e.irl);
        chk("acc_load_pulses", acl, e.acl);
        chk("acc_clr_pulses", aclr, e.aclr);
        chk("pc_load_pulses", pcl, e.pcl);
        chk("alu_op", alu_or, e.alu);
        chk("end_kind", obs_end, e.endk);
        chk("instr_count", instr_count, e.cnt);
        chk("instr_count_sat3", s_instr_count, (e.cnt > 7) ? 7 : e.cnt);
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            inwin = 0;
        end else begin
            if (inwin && (pc_to_mar || halted)) close_win();
            if (pc_to_mar) begin
                inwin = 1;
                cyc = 0; mrd = 0; mwr = 0; irl = 0; pinc = 0;
                acl = 0; aclr = 0; pcl = 0; alu_or = 0;
                chk("flags_at_fetch", {busy, halted, illegal, mem_err}, 4'b1000);
            end else if (halted) begin
                inwin = 0;
            end
            if (inwin) begin
                cyc++;
                mrd += mem_rd; mwr += mem_wr; irl += ir_load; pinc += pc_inc;
                acl += acc_load; aclr += acc_clr; pcl += pc_load;
                alu_or |= alu_op;
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; dec_y = '0; flag_z = 1'b0; flag_n = 1'b0; mem_ack = 1'b0;
        build_programs();
        #3;
        chk("reset_outputs", strobes(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();
        chk("idle_after_reset", {busy, halted, pc_to_mar}, 0);

        mon_en = 1;
        while (prog.size() > 0) run_program();
        repeat (2) cycle();
        chk("scoreboard_drained", sb.size(), 0);
        mon_en = 0;

        // Asynchronous reset in the middle of a store's write handshake
        start = 1'b1;
        cycle();
        start = 1'b0;
        dec_y = oh(L_STA);
        guard = 0;
        while (!mem_wr && guard < 30) begin
            mem_ack = mem_rd;
            cycle();
            guard++;
        end
        mem_ack = 1'b0;
        chk("store_reaches_write", mem_wr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_strobes", strobes(), 0);
        chk("async_reset_sat_count", s_instr_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        cycle();
        chk("idle_after_mid_reset", {busy, halted, mem_rd, mem_wr}, 0);
        mem_ack = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
